// File: rtl/gpio_seq_ctrl.sv
// rtl/gpio_seq_ctrl.sv - Wishbone-programmable pattern sequencer driving a GPIO DATA_OUT register
module gpio_seq_ctrl #(
  parameter int                    ADDR_WIDTH     = 8,
  parameter int                    DEPTH          = 8,
  parameter logic [ADDR_WIDTH-1:0] GPIO_DATA_ADDR = 8'h00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [31:0]           s_dat_i,
  input  logic                  s_we,
  input  logic [3:0]            s_sel,
  input  logic                  s_stb,
  output logic [31:0]           s_dat_o,
  output logic                  s_ack,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [31:0]           m_dat_o,
  output logic                  m_we,
  output logic [3:0]            m_sel,
  output logic                  m_stb,
  input  logic                  m_ack,
  output logic                  busy,
  output logic                  done_irq
);

  localparam logic [5:0] OFF_CTRL   = 6'h00;
  localparam logic [5:0] OFF_STATUS = 6'h01;
  localparam logic [5:0] OFF_PERIOD = 6'h02;
  localparam logic [5:0] OFF_LEN    = 6'h03;
  localparam int         OFF_PAT    = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_WAIT
  } state_t;

  state_t      state;
  logic [3:0]  idx;
  logic [15:0] cnt;
  logic        done_q;
  logic        stop_pend;

  logic        loop_q;
  logic [15:0] period_q;
  logic [3:0]  len_q;
  logic [31:0] pat [DEPTH];

  logic        acc;
  logic        wr_en;
  logic [5:0]  off;
  logic        start_req;
  logic        stop_req;
  logic [31:0] rdata;
  logic [15:0] eff_period;
  logic [3:0]  eff_len;
  logic        last;
  logic [3:0]  fetch_idx;
  logic [31:0] fetch_dat;
  logic        unused_addr;

  // Only word offsets within the low 256 bytes are decoded.
  assign unused_addr = ^s_addr;

  assign acc   = s_stb && !s_ack;
  assign wr_en = acc && s_we;
  assign off   = s_addr[7:2];

  // STOP wins over START when both bits are written together.
  assign start_req = wr_en && (off == OFF_CTRL) && s_sel[0] && s_dat_i[0] && !s_dat_i[2];
  assign stop_req  = wr_en && (off == OFF_CTRL) && s_sel[0] && s_dat_i[2];

  assign busy       = (state != S_IDLE);
  assign eff_period = (period_q == 16'd0) ? 16'd1 : period_q;
  assign eff_len    = (int'(len_q) > DEPTH) ? 4'(DEPTH) : len_q;
  assign last       = (idx == (eff_len - 4'd1));

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[b*8 +: 8] = sel[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return r;
  endfunction

  // Pattern entry that the next WR state will present; sampled on WR entry.
  always_comb begin
    fetch_idx = 4'd0;
    if (state == S_WAIT && !last) begin
      fetch_idx = idx + 4'd1;
    end
    fetch_dat = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fetch_idx == 4'(i)) begin
        fetch_dat = pat[i];
      end
    end
  end

  // Register read decode.
  always_comb begin
    rdata = 32'd0;
    case (off)
      OFF_CTRL:   rdata = {30'd0, loop_q, 1'b0};
      OFF_STATUS: rdata = {25'd0, idx[2:0], 2'b00, done_q, busy};
      OFF_PERIOD: rdata = {16'd0, period_q};
      OFF_LEN:    rdata = {28'd0, len_q};
      default: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (off == 6'(OFF_PAT + i)) begin
            rdata = pat[i];
          end
        end
      end
    endcase
  end

  // Slave handshake: ack one cycle after strobe, capture read data in the access cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ack   <= 1'b0;
      s_dat_o <= 32'd0;
    end else begin
      s_ack <= acc;
      if (acc) begin
        s_dat_o <= rdata;
      end
    end
  end

  // Configuration registers; PERIOD/LEN are frozen while a sequence runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loop_q   <= 1'b0;
      period_q <= 16'd0;
      len_q    <= 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
        pat[i] <= 32'd0;
      end
    end else if (wr_en) begin
      case (off)
        OFF_CTRL: begin
          if (s_sel[0]) loop_q <= s_dat_i[1];
        end
        OFF_PERIOD: begin
          if (!busy) begin
            if (s_sel[0]) period_q[7:0]  <= s_dat_i[7:0];
            if (s_sel[1]) period_q[15:8] <= s_dat_i[15:8];
          end
        end
        OFF_LEN: begin
          if (!busy && s_sel[0]) len_q <= s_dat_i[3:0];
        end
        default: begin
          for (int i = 0; i < DEPTH; i++) begin
            if (off == 6'(OFF_PAT + i)) begin
              pat[i] <= byte_merge(pat[i], s_dat_i, s_sel);
            end
          end
        end
      endcase
    end
  end

  // Sequencer FSM with registered master-bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= 4'd0;
      cnt       <= 16'd0;
      done_q    <= 1'b0;
      done_irq  <= 1'b0;
      stop_pend <= 1'b0;
      m_stb     <= 1'b0;
      m_we      <= 1'b0;
      m_sel     <= 4'd0;
      m_addr    <= '0;
      m_dat_o   <= 32'd0;
    end else begin
      done_irq <= 1'b0;
      case (state)
        S_IDLE: begin
          stop_pend <= 1'b0;
          if (start_req) begin
            if (eff_len == 4'd0) begin
              done_q   <= 1'b1;
              done_irq <= 1'b1;
            end else begin
              done_q  <= 1'b0;
              idx     <= 4'd0;
              state   <= S_WR;
              m_stb   <= 1'b1;
              m_we    <= 1'b1;
              m_sel   <= 4'hF;
              m_addr  <= GPIO_DATA_ADDR;
              m_dat_o <= fetch_dat;
            end
          end
        end
        S_WR: begin
          // A STOP here must let the outstanding transfer finish first.
          if (stop_req) stop_pend <= 1'b1;
          if (m_ack) begin
            m_stb <= 1'b0;
            m_we  <= 1'b0;
            m_sel <= 4'd0;
            if (stop_pend || stop_req) begin
              stop_pend <= 1'b0;
              idx       <= 4'd0;
              state     <= S_IDLE;
            end else begin
              cnt   <= eff_period;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (stop_req) begin
            idx   <= 4'd0;
            state <= S_IDLE;
          end else if (cnt <= 16'd1) begin
            if (!last || loop_q) begin
              idx     <= fetch_idx;
              state   <= S_WR;
              m_stb   <= 1'b1;
              m_we    <= 1'b1;
              m_sel   <= 4'hF;
              m_addr  <= GPIO_DATA_ADDR;
              m_dat_o <= fetch_dat;
            end else begin
              done_q   <= 1'b1;
              done_irq <= 1'b1;
              idx      <= 4'd0;
              state    <= S_IDLE;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/gpio_seq_ctrl.md
GPIO_SEQ_CTRL -- requirements
Module: gpio_seq_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, giving the width of both Wishbone address buses.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the number of pattern entries.
REQ-003 The block SHALL have parameter GPIO_DATA_ADDR, default 8'h00, giving the master-side target address (GPIO DATA_OUT).
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 s_addr/s_dat_i/s_we/s_sel/s_stb  in  ADDR_WIDTH/32/1/4/1  CPU-side Wishbone slave inputs.
REQ-007 s_dat_o/s_ack  out  32/1  CPU-side Wishbone slave outputs.
REQ-008 m_addr/m_dat_o/m_we/m_sel/m_stb  out  ADDR_WIDTH/32/1/4/1  Wishbone master to the GPIO slave.
REQ-009 m_ack  in  1  GPIO slave acknowledge.
REQ-010 busy  out  1  sequence active; done_irq  out  1  one-cycle pulse at normal sequence end.

Function
REQ-011 Slave s_ack SHALL be s_stb && !s_ack, registered, so every access takes exactly 2 cycles; register write and read-data capture occur in the cycle where s_stb && !s_ack.
REQ-012 Register map, decoded on s_addr[7:2]: 0x00 CTRL, 0x04 STATUS, 0x08 PERIOD, 0x0C LEN, 0x20+4*i PAT[i] for i<DEPTH; reads of unmapped offsets return 0, and writes to them are dropped.
REQ-013 CTRL bit0 START and bit2 STOP SHALL be write-1 pulses that read as 0; bit1 LOOP SHALL be a read/write bit.
REQ-014 STATUS SHALL be read-only: bit0 BUSY, bit1 DONE (sticky), bits[6:4] current index, others 0.
REQ-015 PERIOD[15:0] SHALL set the WAIT length in cycles, with 0 treated as 1; LEN[3:0] SHALL set the step count, with values >DEPTH treated as DEPTH.
REQ-016 Writes to PERIOD and LEN while BUSY=1 SHALL be ignored; PAT writes SHALL always be accepted and take effect when that entry is next fetched.
REQ-017 The FSM states SHALL be IDLE, WR and WAIT.
REQ-018 IDLE: START with LEN!=0 SHALL clear DONE, set index 0 and enter WR; START with LEN==0 SHALL set DONE, pulse done_irq and remain in IDLE.
REQ-019 WR: the block SHALL drive m_stb=1, m_we=1, m_sel=4'hF, m_addr=GPIO_DATA_ADDR and m_dat_o=PAT[index], all held stable until m_ack=1.
REQ-020 On m_ack in WR, m_stb SHALL be 0 from the next cycle, the counter SHALL load PERIOD, and the FSM SHALL enter WAIT.
REQ-021 WAIT SHALL last exactly PERIOD cycles; at its end, if index<LEN-1 the block SHALL increment the index and enter WR.
REQ-022 At the end of WAIT with index==LEN-1 and LOOP=1, the block SHALL set index 0 and enter WR.
REQ-023 At the end of WAIT with index==LEN-1 and LOOP=0, the block SHALL set DONE, pulse done_irq for 1 cycle and enter IDLE.
REQ-024 With a 1-cycle-ack GPIO slave, consecutive m_stb rising edges SHALL be PERIOD+2 cycles apart.
REQ-025 STOP in WAIT SHALL enter IDLE on the next cycle; STOP in WR SHALL complete the outstanding transfer (wait for m_ack) and then enter IDLE. Neither case sets DONE or pulses done_irq.
REQ-026 START while BUSY SHALL be ignored; START and STOP written together SHALL act as STOP only.
REQ-027 busy SHALL be 1 exactly when the state is not IDLE; m_stb SHALL never be asserted outside WR.
REQ-028 Clearing LOOP mid-sequence SHALL take effect at the next end-of-sequence check.

Reset
REQ-029 On rst_n=0 the FSM SHALL go to IDLE and s_ack, s_dat_o, m_stb, m_we, m_sel, m_addr, m_dat_o, busy, done_irq, CTRL, STATUS, PERIOD, LEN and index SHALL all be 0; PAT contents SHALL be 0.
REQ-030 Reset asserted mid-transfer SHALL drop m_stb immediately (asynchronously) with no completion of the transfer.

Verification
REQ-031 Write PAT0=0x1, PAT1=0x2, PAT2=0x4, PERIOD=3, LEN=3, CTRL=0x1 -> three master writes of 0x1, 0x2, 0x4 to address 0x00, 5 cycles apart; done_irq pulses once; STATUS reads 0x2.
REQ-032 Same setup with CTRL=0x3 (LOOP) -> the write sequence 0x1, 0x2, 0x4, 0x1... repeats; write CTRL=0x4 during WAIT -> IDLE next cycle, DONE=0, no done_irq.
REQ-033 LEN=0, START -> no master activity, DONE=1, one done_irq pulse.
REQ-034 Slave stalls m_ack for 4 cycles -> m_stb and m_dat_o held stable; STOP issued during the stall takes effect only after the ack.
REQ-035 PERIOD=0, LEN=2 -> writes 3 cycles apart; a write of PERIOD=9 while busy reads back as 0.
REQ-036 rst_n pulsed low while m_stb=1 -> m_stb=0 with no clock edge, all registers read 0 afterwards.
